// File: rtl/ps2_cmd_sequencer_if.sv
// Byte-level handshake between the command sequencer and a PS/2 transceiver.
// The sequencer is the master: it issues bytes and consumes received bytes.
interface ps2_cmd_sequencer_if;
   logic       ps2_read;
   logic [7:0] rx_data;
   logic       ps2_busy;
   logic       ps2_write;
   logic [7:0] tx_data;

   modport master (
      input  ps2_read, rx_data, ps2_busy,
      output ps2_write, tx_data
   );

   modport slave (
      output ps2_read, rx_data, ps2_busy,
      input  ps2_write, tx_data
   );
endinterface

// File: rtl/ps2_cmd_sequencer.sv
// PS/2 keyboard init / LED command sequencer with ACK retry and timeouts.
// Define PS2_TYPEMATIC_EN to send F3,TYPEMATIC_BYTE between self-test and F4.
module ps2_cmd_sequencer #(
   parameter int unsigned TIMEOUT_CYCLES = 2500000,
   parameter int unsigned BAT_CYCLES     = 25000000,
   parameter int unsigned MAX_RETRIES    = 3,
   parameter logic [7:0]  TYPEMATIC_BYTE = 8'h20
) (
   input  logic                clk,
   input  logic                rst,
   ps2_cmd_sequencer_if.master ps2,
   input  logic                led_req,
   input  logic [2:0]          led_state,
   input  logic                restart,
   output logic                init_done,
   output logic                cmd_busy,
   output logic                error
);

   typedef enum logic [2:0] {
      LOAD, ISSUE, WAIT_ACK, WAIT_BAT, IDLE, FAULT
   } state_t;

   localparam logic [2:0] S_FF  = 3'd0;
   localparam logic [2:0] S_F3  = 3'd1;
   localparam logic [2:0] S_TM  = 3'd2;
   localparam logic [2:0] S_F4  = 3'd3;
   localparam logic [2:0] S_ED  = 3'd4;
   localparam logic [2:0] S_LED = 3'd5;

`ifdef PS2_TYPEMATIC_EN
   localparam logic [2:0] S_POST_BAT = S_F3;
`else
   localparam logic [2:0] S_POST_BAT = S_F4;
`endif

   localparam int unsigned CMAX =
      (BAT_CYCLES > TIMEOUT_CYCLES) ? BAT_CYCLES : TIMEOUT_CYCLES;
   localparam int CW = $clog2(CMAX + 1);
   localparam int RW = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);

   state_t          state, state_d;
   logic [2:0]      step, step_d;
   logic [RW-1:0]   retry, retry_d;
   logic [CW-1:0]   cnt;
   logic            pending;
   logic [2:0]      led_latch, led_cur;
   logic [7:0]      cur_byte;
   logic            led_go, done_set;
   logic            ack_to, bat_to;
   logic            rx_fa, rx_fe, rx_aa, rx_fc;
   logic            write_d;
   logic [7:0]      tx_d;
   logic            busy_d, err_d;

   assign rx_fa  = ps2.ps2_read && (ps2.rx_data == 8'hFA);
   assign rx_fe  = ps2.ps2_read && (ps2.rx_data == 8'hFE);
   assign rx_aa  = ps2.ps2_read && (ps2.rx_data == 8'hAA);
   assign rx_fc  = ps2.ps2_read && (ps2.rx_data == 8'hFC);
   assign ack_to = (state == WAIT_ACK) && (cnt == CW'(TIMEOUT_CYCLES - 1));
   assign bat_to = (state == WAIT_BAT) && (cnt == CW'(BAT_CYCLES - 1));

   always_comb begin
      cur_byte = 8'hFF;
      case (step)
         S_FF:    cur_byte = 8'hFF;
         S_F3:    cur_byte = 8'hF3;
         S_TM:    cur_byte = TYPEMATIC_BYTE;
         S_F4:    cur_byte = 8'hF4;
         S_ED:    cur_byte = 8'hED;
         S_LED:   cur_byte = {5'b0, led_cur};
         default: cur_byte = 8'hFF;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= LOAD;
      else     state <= state_d;
   end

   always_comb begin
      state_d  = state;
      step_d   = step;
      retry_d  = retry;
      led_go   = 1'b0;
      done_set = 1'b0;
      case (state)
         LOAD: begin
            step_d  = S_FF;
            state_d = ISSUE;
         end
         ISSUE: begin
            if (!ps2.ps2_busy) state_d = WAIT_ACK;
         end
         WAIT_ACK: begin
            if (rx_fa) begin
               retry_d = '0;
               case (step)
                  S_FF:    state_d = WAIT_BAT;
                  S_F4: begin
                     state_d  = IDLE;
                     done_set = 1'b1;
                  end
                  S_LED:   state_d = IDLE;
                  default: begin
                     step_d  = step + 3'd1;
                     state_d = ISSUE;
                  end
               endcase
            end else if (rx_fe || ack_to) begin
               if (retry == RW'(MAX_RETRIES)) begin
                  state_d = FAULT;
               end else begin
                  retry_d = retry + RW'(1);
                  state_d = ISSUE;
               end
            end
         end
         WAIT_BAT: begin
            if (rx_aa) begin
               step_d  = S_POST_BAT;
               state_d = ISSUE;
            end else if (rx_fc || bat_to) begin
               state_d = FAULT;
            end
         end
         IDLE: begin
            if (pending) begin
               step_d  = S_ED;
               state_d = ISSUE;
               led_go  = 1'b1;
            end
         end
         FAULT: ;
         default: state_d = LOAD;
      endcase
      if (restart) begin
         state_d  = LOAD;
         retry_d  = '0;
         led_go   = 1'b0;
         done_set = 1'b0;
      end
   end

   always_comb begin
      write_d = (state == ISSUE) && !ps2.ps2_busy && !restart;
      tx_d    = write_d ? cur_byte : ps2.tx_data;
      busy_d  = (state_d == LOAD) || (state_d == ISSUE) ||
                (state_d == WAIT_ACK) || (state_d == WAIT_BAT);
      err_d   = (state_d == FAULT);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         step          <= S_FF;
         retry         <= '0;
         cnt           <= '0;
         pending       <= 1'b0;
         led_latch     <= 3'b0;
         led_cur       <= 3'b0;
         init_done     <= 1'b0;
         ps2.ps2_write <= 1'b0;
         ps2.tx_data   <= 8'h00;
         cmd_busy      <= 1'b0;
         error         <= 1'b0;
      end else begin
         step          <= step_d;
         retry         <= retry_d;
         ps2.ps2_write <= write_d;
         ps2.tx_data   <= tx_d;
         cmd_busy      <= busy_d;
         error         <= err_d;
         // counter restarts whenever a wait state is (re)entered
         if ((state_d == state) &&
             ((state == WAIT_ACK) || (state == WAIT_BAT)))
            cnt <= cnt + CW'(1);
         else
            cnt <= '0;
         if (led_req && (state != FAULT)) begin
            pending   <= 1'b1;
            led_latch <= led_state;
         end else if (led_go) begin
            pending <= 1'b0;
         end
         if (led_go) led_cur <= led_latch;
         if (restart || (state_d == FAULT)) init_done <= 1'b0;
         else if (done_set)                 init_done <= 1'b1;
      end
   end

endmodule

// File: tb/tb_ps2_cmd_sequencer.sv
// Directed bench for ps2_cmd_sequencer: keyboard responses are scripted,
// expected tx bytes go through a scoreboard queue.
module tb_ps2_cmd_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       led_req = 1'b0;
   logic [2:0] led_state = 3'b0;
   logic       restart = 1'b0;
   logic       init_done, cmd_busy, error;

   int n_assert = 0;
   int n_fail   = 0;
   int wr_cnt   = 0;
   int base;
   logic [7:0] exp_q[$];

   ps2_cmd_sequencer_if ps();

   ps2_cmd_sequencer #(
      .TIMEOUT_CYCLES(100),
      .BAT_CYCLES    (500),
      .MAX_RETRIES   (3),
      .TYPEMATIC_BYTE(8'h2A)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .ps2      (ps),
      .led_req  (led_req),
      .led_state(led_state),
      .restart  (restart),
      .init_done(init_done),
      .cmd_busy (cmd_busy),
      .error    (error)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (ps.ps2_write === 1'b1) wr_cnt++;

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send(logic [7:0] b);
      ps.ps2_read = 1'b1;
      ps.rx_data  = b;
      @(negedge clk);
      ps.ps2_read = 1'b0;
      ps.rx_data  = 8'h00;
   endtask

   task automatic wait_tx(string tag, int budget);
      logic [7:0] e;
      bit got;
      got = 1'b0;
      e   = 8'hxx;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (ps.ps2_write === 1'b1) begin
            got = 1'b1;
            break;
         end
      end
      check({tag, "_seen"}, 32'(got), 32'd1);
      if (got) begin
         if (exp_q.size() > 0) e = exp_q.pop_front();
         check(tag, 32'(ps.tx_data), 32'(e));
         @(negedge clk);
         check({tag, "_pulse"}, 32'(ps.ps2_write), 32'd0);
         check({tag, "_hold"}, 32'(ps.tx_data), 32'(e));
      end
   endtask

   task automatic pulse_restart();
      restart = 1'b1;
      @(negedge clk);
      restart = 1'b0;
   endtask

   // FF already observed: ACK it, pass self-test, finish through F4
   task automatic finish_init(string tag);
      send(8'hFA);
      send(8'hAA);
`ifdef PS2_TYPEMATIC_EN
      exp_q.push_back(8'hF3);
      wait_tx({tag, "_f3"}, 5);
      send(8'hFA);
      exp_q.push_back(8'h2A);
      wait_tx({tag, "_tm"}, 5);
      send(8'hFA);
`endif
      exp_q.push_back(8'hF4);
      wait_tx({tag, "_f4"}, 5);
      send(8'hFA);
   endtask

   initial begin
      ps.ps2_read = 1'b0;
      ps.rx_data  = 8'h00;
      ps.ps2_busy = 1'b0;
      tick(3);
      check("rst_write", 32'(ps.ps2_write), 32'd0);
      check("rst_tx", 32'(ps.tx_data), 32'h00);
      check("rst_done", 32'(init_done), 32'd0);
      check("rst_busy", 32'(cmd_busy), 32'd0);
      check("rst_err", 32'(error), 32'd0);

      // first write must land on the second edge after release
      rst = 1'b0;
      exp_q.push_back(8'hFF);
      @(negedge clk);
      check("first_edge_write", 32'(ps.ps2_write), 32'd0);
      check("load_busy", 32'(cmd_busy), 32'd1);
      wait_tx("init_ff", 1);
      send(8'h55);
      check("ignore_busy", 32'(cmd_busy), 32'd1);
      finish_init("init");
      tick(2);
      check("init_done", 32'(init_done), 32'd1);
      check("init_err", 32'(error), 32'd0);
      check("init_idle", 32'(cmd_busy), 32'd0);
`ifdef PS2_TYPEMATIC_EN
      check("init_wr_cnt", 32'(wr_cnt), 32'd4);
`else
      check("init_wr_cnt", 32'(wr_cnt), 32'd2);
`endif
      send(8'hFA);
      check("idle_read_ignored", 32'(cmd_busy), 32'd0);

      // LED update, second request arrives while ED awaits ACK
      led_state = 3'b101;
      led_req   = 1'b1;
      @(negedge clk);
      led_req   = 1'b0;
      exp_q.push_back(8'hED);
      exp_q.push_back(8'h05);
      wait_tx("led1_ed", 5);
      led_state = 3'b010;
      led_req   = 1'b1;
      @(negedge clk);
      led_req   = 1'b0;
      send(8'hFA);
      wait_tx("led1_val", 5);
      send(8'hFA);
      exp_q.push_back(8'hED);
      exp_q.push_back(8'h02);
      wait_tx("led2_ed", 5);
      send(8'hFA);
      wait_tx("led2_val", 5);
      send(8'hFA);
      tick(3);
      check("led_done", 32'(init_done), 32'd1);
      check("led_idle", 32'(cmd_busy), 32'd0);

      // two FE retries on F4
      pulse_restart();
      check("restart_clr_done", 32'(init_done), 32'd0);
      exp_q.push_back(8'hFF);
      wait_tx("rty_ff", 5);
      send(8'hFA);
      send(8'hAA);
`ifdef PS2_TYPEMATIC_EN
      exp_q.push_back(8'hF3);
      wait_tx("rty_f3", 5);
      send(8'hFA);
      exp_q.push_back(8'h2A);
      wait_tx("rty_tm", 5);
      send(8'hFA);
`endif
      base = wr_cnt;
      for (int k = 0; k < 2; k++) begin
         exp_q.push_back(8'hF4);
         wait_tx("rty_f4", 5);
         send(8'hFE);
      end
      exp_q.push_back(8'hF4);
      wait_tx("rty_f4_last", 5);
      send(8'hFA);
      tick(2);
      check("rty_f4_cnt", 32'(wr_cnt - base), 32'd3);
      check("rty_done", 32'(init_done), 32'd1);
      check("rty_err", 32'(error), 32'd0);

      // silent keyboard: original + 3 retries, then FAULT
      pulse_restart();
      base = wr_cnt;
      for (int k = 0; k < 4; k++) begin
         exp_q.push_back(8'hFF);
         wait_tx("to_ff", 110);
      end
      tick(98);
      check("to_err_early", 32'(error), 32'd0);
      tick(1);
      check("to_err", 32'(error), 32'd1);
      check("to_done", 32'(init_done), 32'd0);
      check("to_busy", 32'(cmd_busy), 32'd0);
      led_req = 1'b1;
      @(negedge clk);
      led_req = 1'b0;
      send(8'hFA);
      tick(200);
      check("to_wr_cnt", 32'(wr_cnt - base), 32'd4);
      check("fault_sticky", 32'(error), 32'd1);

      // self-test failure, then restart with transceiver busy
      pulse_restart();
      check("restart_clr_err", 32'(error), 32'd0);
      exp_q.push_back(8'hFF);
      wait_tx("fc_ff", 5);
      send(8'hFA);
      send(8'hFC);
      check("fc_err", 32'(error), 32'd1);
      ps.ps2_busy = 1'b1;
      pulse_restart();
      base = wr_cnt;
      tick(50);
      check("busy_no_write", 32'(wr_cnt - base), 32'd0);
      check("busy_cmd_busy", 32'(cmd_busy), 32'd1);
      check("busy_err_clr", 32'(error), 32'd0);
      ps.ps2_busy = 1'b0;
      exp_q.push_back(8'hFF);
      wait_tx("busy_ff", 3);
      finish_init("fc");
      tick(5);
      check("fc_done", 32'(init_done), 32'd1);
      check("fc_idle", 32'(cmd_busy), 32'd0);
      check("fault_led_ignored", 32'(wr_cnt - base), 32'd0 +
`ifdef PS2_TYPEMATIC_EN
            32'd4
`else
            32'd2
`endif
      );
      check("sb_empty", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

endmodule
